// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Execute-stage sequencer in front of a combinational RV32I ALU. An operation
// is accepted over a valid/ready handshake, decoded into a 4-bit ALU control
// code, issued to the ALU for exactly one cycle, and the captured result,
// branch decision and illegal flag are then offered downstream on a second
// valid/ready handshake.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (ready only while idle)
//   alu_op, funct3,
//   funct7b5            decoded instruction fields
//   op_a, op_b          operands (op_b already muxed register/immediate)
//   alu_a/alu_b/alu_ctrl  drive the external ALU
//   alu_result/alu_zero   returned by the external ALU
//   out_valid/out_ready downstream handshake
//   out_result, out_branch_taken, out_illegal  captured outputs
//   op_count            completed output handshakes (wrapping)
module alu_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_branch_taken,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]  a_q, b_q;
  logic [3:0]       ctrl_q;
  logic             beq_q, bne_q, ill_q;
  logic [XLEN-1:0]  result_q;
  logic             taken_q, illegal_q;
  logic [CNT_W-1:0] count_q;

  logic [3:0] dec_ctrl;
  logic       dec_beq, dec_bne, dec_ill;
  logic       accept, handshake;

  assign accept    = (state_q == IDLE) && in_valid;
  assign handshake = (state_q == DONE) && out_ready;

  // Decode the instruction fields. Everything starts out illegal with the
  // idle control code, and only recognised encodings overwrite that, so an
  // unsupported encoding naturally issues 1111 and the ALU returns 0.
  always_comb begin
    dec_ctrl = CTRL_IDLE;
    dec_beq  = 1'b0;
    dec_bne  = 1'b0;
    dec_ill  = 1'b1;
    case (alu_op)
      2'b00: begin
        dec_ctrl = CTRL_ADD;
        dec_ill  = 1'b0;
      end
      2'b01: begin
        if (funct3 == 3'b000) begin
          dec_ctrl = CTRL_SUB;
          dec_beq  = 1'b1;
          dec_ill  = 1'b0;
        end else if (funct3 == 3'b001) begin
          dec_ctrl = CTRL_SUB;
          dec_bne  = 1'b1;
          dec_ill  = 1'b0;
        end
      end
      default: begin
        // R-type and I-type share the funct3 map; only R-type uses bit 30
        case (funct3)
          3'b000: begin
            dec_ctrl = (alu_op == 2'b10 && funct7b5) ? CTRL_SUB : CTRL_ADD;
            dec_ill  = 1'b0;
          end
          3'b111: begin
            dec_ctrl = CTRL_AND;
            dec_ill  = 1'b0;
          end
          3'b110: begin
            dec_ctrl = CTRL_OR;
            dec_ill  = 1'b0;
          end
          default: ;
        endcase
      end
    endcase
  end

  // Next-state logic; inputs outside IDLE are simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand and decode registers, loaded on accept and held through EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= CTRL_IDLE;
      beq_q  <= 1'b0;
      bne_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= op_a;
      b_q    <= op_b;
      ctrl_q <= dec_ctrl;
      beq_q  <= dec_beq;
      bne_q  <= dec_bne;
      ill_q  <= dec_ill;
    end
  end

  // Capture the ALU response at the end of EXEC. The result of an illegal
  // op is forced to zero rather than trusting the ALU's idle value.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (state_q == EXEC) begin
      result_q  <= ill_q ? '0 : alu_result;
      taken_q   <= (beq_q & alu_zero) | (bne_q & ~alu_zero);
      illegal_q <= ill_q;
    end
  end

  // Completed-operation counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (rst)            count_q <= '0;
    else if (handshake) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // The ALU is only fed real operands during EXEC so it idles at zero.
  assign alu_a    = (state_q == EXEC) ? a_q    : '0;
  assign alu_b    = (state_q == EXEC) ? b_q    : '0;
  assign alu_ctrl = (state_q == EXEC) ? ctrl_q : CTRL_IDLE;

  assign in_ready         = (state_q == IDLE);
  assign out_valid        = (state_q == DONE);
  assign out_result       = result_q;
  assign out_branch_taken = taken_q;
  assign out_illegal      = illegal_q;
  assign op_count         = count_q;

endmodule
